// File: rtl/cpu_stall_injector_if.sv
// Stall injector bus: enable, per-channel config writes, stall outputs, stats.
// master drives enable/cfg/stat_sel; slave returns stall_o and stat_count.
interface cpu_stall_injector_if #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1,
  parameter int DUTY_W = 8,
  parameter int LFSR_W = 16
);
  logic              enable;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [DUTY_W-1:0] cfg_period;
  logic [DUTY_W-1:0] cfg_duty;
  logic [LFSR_W-1:0] cfg_seed;
  logic [NUM_CH-1:0] stall_o;
  logic [CH_W-1:0]   stat_sel;
  logic [31:0]       stat_count;

  modport master (
    output enable, cfg_we, cfg_ch, cfg_mode,
    output cfg_period, cfg_duty, cfg_seed, stat_sel,
    input  stall_o, stat_count
  );

  modport slave (
    input  enable, cfg_we, cfg_ch, cfg_mode,
    input  cfg_period, cfg_duty, cfg_seed, stat_sel,
    output stall_o, stat_count
  );
endinterface

// File: rtl/cpu_stall_injector.sv
// Per-channel stall generator (off/always/periodic/random) with run limiter.
// Ports: clock, reset (async high), bus (slave): cfg in, stall_o/stats out.
module cpu_stall_injector #(
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 1,
  parameter int DUTY_W  = 8,
  parameter int LFSR_W  = 16,
  parameter int MAX_RUN = 16
) (
  input logic                  clock,
  input logic                  reset,
  cpu_stall_injector_if.slave  bus
);

  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_ALWAYS = 2'd1,
    M_PERIOD = 2'd2,
    M_RANDOM = 2'd3
  } mode_e;

  localparam int RUN_W =
    (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);
  localparam logic [LFSR_W-1:0] MASK =
    LFSR_W'(16'hB400);

  mode_e             mode_q   [NUM_CH];
  logic [DUTY_W-1:0] period_q [NUM_CH];
  logic [DUTY_W-1:0] duty_q   [NUM_CH];
  logic [DUTY_W-1:0] phase_q  [NUM_CH];
  logic [LFSR_W-1:0] lfsr_q   [NUM_CH];
  logic [RUN_W-1:0]  run_q    [NUM_CH];
  logic [31:0]       stat_q   [NUM_CH];
  logic [NUM_CH-1:0] stall_q;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] lim;
  logic [NUM_CH-1:0] eff;
  logic [DUTY_W-1:0] phase_nxt [NUM_CH];
  logic [LFSR_W-1:0] lfsr_nxt  [NUM_CH];
  logic [31:0]       stat_mux;

  always_comb begin
    raw = '0;
    lim = '0;
    eff = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      phase_nxt[i] = '0;
      lfsr_nxt[i]  = '0;
      unique case (mode_q[i])
        M_OFF:    raw[i] = 1'b0;
        M_ALWAYS: raw[i] = 1'b1;
        M_PERIOD: raw[i] = phase_q[i] < duty_q[i];
        M_RANDOM:
          raw[i] = lfsr_q[i][DUTY_W-1:0] < duty_q[i];
        default:  raw[i] = 1'b0;
      endcase
      lim[i] = (MAX_RUN != 0) &&
               (run_q[i] == RUN_W'(MAX_RUN));
      eff[i] = raw[i] & ~lim[i];
      // period 0 pins the phase at 0
      if (phase_q[i] >= period_q[i])
        phase_nxt[i] = '0;
      else
        phase_nxt[i] = phase_q[i] + DUTY_W'(1);
      // Galois right shift
      if (lfsr_q[i][0])
        lfsr_nxt[i] = (lfsr_q[i] >> 1) ^ MASK;
      else
        lfsr_nxt[i] = lfsr_q[i] >> 1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= M_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        phase_q[i]  <= '0;
        lfsr_q[i]   <= LFSR_W'(1);
        run_q[i]    <= '0;
        stat_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stall_q[i] && (stat_q[i] != '1))
          stat_q[i] <= stat_q[i] + 32'd1;
        if (bus.enable) begin
          stall_q[i] <= eff[i];
          phase_q[i] <= phase_nxt[i];
          lfsr_q[i]  <= lfsr_nxt[i];
          if (lim[i] || !eff[i])
            run_q[i] <= '0;
          else
            run_q[i] <= run_q[i] + RUN_W'(1);
        end else begin
          stall_q[i] <= 1'b0;
        end
        // a write overrides this cycle's counter updates
        if (bus.cfg_we && (int'(bus.cfg_ch) == i)) begin
          mode_q[i]   <= mode_e'(bus.cfg_mode);
          period_q[i] <= bus.cfg_period;
          duty_q[i]   <= bus.cfg_duty;
          phase_q[i]  <= '0;
          run_q[i]    <= '0;
          lfsr_q[i]   <= (bus.cfg_seed == '0) ?
                         LFSR_W'(1) : bus.cfg_seed;
        end
      end
    end
  end

  always_comb begin
    stat_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (int'(bus.stat_sel) == i)
        stat_mux = stat_q[i];
  end

  assign bus.stall_o    = stall_q;
  assign bus.stat_count = stat_mux;

endmodule

// File: tb/tb_cpu_stall_injector.sv
// Bench for cpu_stall_injector: vector table, directed corners, random vs model.
// Drives the bus interface as master; clock generated locally.
module tb_cpu_stall_injector;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  cpu_stall_injector_if #(
    .NUM_CH(2), .CH_W(1), .DUTY_W(8), .LFSR_W(16)
  ) bus ();

  cpu_stall_injector #(
    .NUM_CH(2), .CH_W(1), .DUTY_W(8),
    .LFSR_W(16), .MAX_RUN(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [15:0] gal(logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // reference model: phase is elapsed enabled cycles mod (period+1)
  int          m_mode [2];
  int          m_per  [2];
  int          m_duty [2];
  int          m_t    [2];
  int          m_run  [2];
  logic [15:0] m_lfsr [2];
  bit          m_stall[2];
  longint      m_stat [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0;
      m_t[i] = 0; m_run[i] = 0; m_lfsr[i] = 16'h0001;
      m_stall[i] = 0; m_stat[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      bit raw;
      bit lim;
      bit eff;
      if (m_stall[i] && m_stat[i] < 64'hFFFFFFFF) m_stat[i]++;
      if (bus.enable) begin
        case (m_mode[i])
          1: raw = 1;
          2: raw = (m_t[i] % (m_per[i] + 1)) < m_duty[i];
          3: raw = int'(m_lfsr[i] & 16'h00FF) < m_duty[i];
          default: raw = 0;
        endcase
        lim = (m_run[i] == 16);
        eff = raw && !lim;
        m_run[i] = eff ? m_run[i] + 1 : 0;
        m_t[i]++;
        m_lfsr[i] = gal(m_lfsr[i]);
        m_stall[i] = eff;
      end else begin
        m_stall[i] = 0;
      end
      if (bus.cfg_we && int'(bus.cfg_ch) == i) begin
        m_mode[i] = int'(bus.cfg_mode);
        m_per[i]  = int'(bus.cfg_period);
        m_duty[i] = int'(bus.cfg_duty);
        m_t[i] = 0;
        m_run[i] = 0;
        m_lfsr[i] = (bus.cfg_seed == 0) ? 16'h0001 : bus.cfg_seed;
      end
    end
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_mode = 0;
    bus.cfg_period = 0; bus.cfg_duty = 0; bus.cfg_seed = 0;
  endtask

  task automatic wr(bit ch, bit [1:0] md, bit [7:0] p,
                    bit [7:0] d, bit [15:0] s);
    bus.cfg_we = 1; bus.cfg_ch = ch; bus.cfg_mode = md;
    bus.cfg_period = p; bus.cfg_duty = d; bus.cfg_seed = s;
  endtask

  task automatic do_reset();
    idle();
    bus.enable = 0;
    reset = 1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
    bus.enable = 1;
  endtask

  typedef struct {
    bit       we;
    bit       en;
    bit [1:0] exp;
  } vec_t;

  vec_t tbl[19];
  bit   exp_seq[4096];

  initial begin
    int mism;
    int ones;
    logic [15:0] l;
    int run;

    // periodic ch1 p=3 d=1, with a 5-cycle enable drop mid-period
    tbl[0] = '{1, 1, 2'b00};
    tbl[1] = '{0, 1, 2'b10};
    tbl[2] = '{0, 1, 2'b00};
    tbl[3] = '{0, 1, 2'b00};
    tbl[4] = '{0, 1, 2'b00};
    tbl[5] = '{0, 1, 2'b10};
    tbl[6] = '{0, 1, 2'b00};
    tbl[7] = '{0, 1, 2'b00};
    tbl[8] = '{0, 1, 2'b00};
    tbl[9] = '{0, 1, 2'b10};
    for (int i = 10; i < 15; i++) tbl[i] = '{0, 0, 2'b00};
    tbl[15] = '{0, 1, 2'b00};
    tbl[16] = '{0, 1, 2'b00};
    tbl[17] = '{0, 1, 2'b00};
    tbl[18] = '{0, 1, 2'b10};

    bus.stat_sel = 0;
    bus.enable = 0;
    idle();
    model_reset();
    #2;
    chk("reset_stall", bus.stall_o, 0);
    chk("reset_stat0", bus.stat_count, 0);
    do_reset();

    // no config: 100 idle enabled cycles
    mism = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.stall_o !== 2'b00) mism++;
    end
    chk("idle_stall", mism, 0);
    chk("idle_stat0", bus.stat_count, 0);
    bus.stat_sel = 1; #1;
    chk("idle_stat1", bus.stat_count, 0);

    // vector table
    do_reset();
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].we) wr(1, 2, 8'd3, 8'd1, 16'd0);
      else idle();
      bus.enable = tbl[i].en;
      step();
      chk($sformatf("tbl[%0d]", i), bus.stall_o, tbl[i].exp);
    end
    idle();
    bus.enable = 1;

    // periodic stat count over 40 outputs
    do_reset();
    wr(1, 2, 8'd3, 8'd1, 16'd0);
    step();
    idle();
    for (int k = 0; k < 41; k++) step();
    bus.stat_sel = 1; #1;
    chk("per_stat1", bus.stat_count, 10);
    bus.stat_sel = 0; #1;
    chk("per_stat0", bus.stat_count, 0);

    // always + limiter: 16 ones then a zero
    do_reset();
    wr(0, 1, 8'd0, 8'd0, 16'd0);
    step();
    idle();
    mism = 0;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (bus.stall_o !== {1'b0, (k % 17) != 0}) mism++;
    end
    chk("always_pattern", mism, 0);
    chk("always_stat", bus.stat_count, 32);

    // random: seed 0 -> lfsr 1, reference sequence
    l = 16'h0001;
    run = 0;
    for (int k = 0; k < 4096; k++) begin
      bit raw;
      raw = l[7:0] < 8'h80;
      exp_seq[k] = raw && (run != 16);
      run = exp_seq[k] ? run + 1 : 0;
      l = gal(l);
    end
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      wr(0, 3, 8'd0, 8'h80, 16'd0);
      step();
      idle();
      mism = 0;
      ones = 0;
      for (int k = 0; k < 4096; k++) begin
        step();
        if (bus.stall_o !== {1'b0, exp_seq[k]}) mism++;
        if (bus.stall_o[0]) ones++;
      end
      chk(pass == 0 ? "rand_seq" : "rand_replay", mism, 0);
      chk("rand_ratio", (ones > 1800 && ones < 2300), 1);
    end

    // async reset while both channels stall
    do_reset();
    wr(0, 1, 8'd0, 8'd0, 16'd0);
    step();
    wr(1, 1, 8'd0, 8'd0, 16'd0);
    step();
    idle();
    step();
    chk("both_stall", bus.stall_o, 2'b11);
    @(negedge clock);
    reset = 1;
    #1;
    chk("async_reset", bus.stall_o, 2'b00);
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
    mism = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.stall_o !== 2'b00) mism++;
    end
    chk("post_reset_off", mism, 0);

    // randomized run against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus.enable = ($urandom % 8) != 0;
      if (($urandom % 6) == 0) begin
        bit [1:0] md;
        md = 2'($urandom % 4);
        wr(1'($urandom % 2), md, 8'($urandom % 8),
           (md == 3) ? 8'($urandom) : 8'($urandom % 10),
           (($urandom % 4) == 0) ? 16'd0 : 16'($urandom));
      end else begin
        idle();
      end
      bus.stat_sel = 1'($urandom % 2);
      step();
      chk("rnd_stall", bus.stall_o, {m_stall[1], m_stall[0]});
      chk("rnd_stat", bus.stat_count, m_stat[bus.stat_sel]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
